iomem_uart: RTL and testbench

- Memory-mapped 8N1 UART that acts as a responder on the SoC iomem bus. The bus is the valid/ready/wstrb/addr/wdata/rdata port set that the CPU-side SoC drives for addresses with addr[31:24] != 0.
- Contains a 4-entry TX FIFO, a single-byte RX holding register, and a programmable bit-period divisor.
- Sits outside the SoC top and connects directly to the iomem_* ports.

---
 rtl/iomem_uart.sv | 247 ++++++++++++++++++++++++
 tb/tb_iomem_uart.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_uart.sv
// Memory-mapped 8N1 UART responder for the SoC iomem bus: 4-deep TX FIFO,
// single-byte RX holding register and a programmable clocks-per-bit divisor.
module iomem_uart #(
   parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
   parameter logic [15:0] DEFAULT_DIV = 16'd104,
   parameter int          TXFIFO_LOG2 = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        ser_tx,
   input  logic        ser_rx
);

   localparam int DEPTH = 1 << TXFIFO_LOG2;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // Valid/ready: a request is held by the initiator until iomem_ready; this
   // block answers with a single-cycle ready pulse, side effects on that edge.
   logic        hit, is_write, push_req, stall, accept;
   logic [5:0]  offset;
   logic [31:0] rd_val;
   logic [15:0] div, eff_div;
   logic        overrun, framing, rx_valid;
   logic [7:0]  rx_data;
   logic        rx_pop, status_clr;

   logic [7:0]             fifo_mem [DEPTH];
   logic [TXFIFO_LOG2:0]   wptr, rptr;
   logic                   tx_full, tx_empty, fifo_push, fifo_pop, tx_idle;

   tx_state_t   tx_state;
   logic [15:0] tx_cnt, tx_div;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_last;

   rx_state_t   rx_state;
   logic [15:0] rx_cnt, rx_div, rx_half;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_s1, rx_s2, rx_prev;
   logic        rx_last, rx_start_done, rx_deliver, rx_frame_err;

   logic unused;
   assign unused = ^{iomem_addr[1:0], iomem_wdata[31:16]};

   assign offset     = iomem_addr[7:2];
   assign hit        = (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign is_write   = |iomem_wstrb;
   assign push_req   = (offset == 6'd0) && iomem_wstrb[0];
   assign stall      = push_req && tx_full;
   assign accept     = iomem_valid && hit && !iomem_ready && !stall;
   assign fifo_push  = accept && push_req;
   assign rx_pop     = accept && (offset == 6'd0) && !is_write && rx_valid;
   assign status_clr = accept && (offset == 6'd1) && iomem_wstrb[0];
   assign eff_div    = (div < 16'd2) ? 16'd2 : div;

   always_comb begin
      rd_val = '0;
      case (offset)
         6'd0:    rd_val = rx_valid ? {24'h0, rx_data} : 32'hFFFF_FFFF;
         6'd1:    rd_val = {27'h0, framing, overrun, rx_valid, tx_idle, tx_full};
         6'd2:    rd_val = {16'h0, div};
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         div         <= DEFAULT_DIV;
         overrun     <= 1'b0;
         framing     <= 1'b0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
      end else begin
         iomem_ready <= accept;
         if (accept)
            iomem_rdata <= is_write ? 32'h0 : rd_val;
         if (accept && (offset == 6'd2)) begin
            if (iomem_wstrb[0]) div[7:0]  <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) div[15:8] <= iomem_wdata[15:8];
         end
         // A pop in the same cycle as a delivery frees the slot for the new byte.
         if (rx_deliver && (!rx_valid || rx_pop)) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
         end else if (rx_pop) begin
            rx_valid <= 1'b0;
         end
         if (rx_deliver && rx_valid && !rx_pop)
            overrun <= 1'b1;
         else if (status_clr && iomem_wdata[3])
            overrun <= 1'b0;
         if (rx_frame_err)
            framing <= 1'b1;
         else if (status_clr && iomem_wdata[4])
            framing <= 1'b0;
      end
   end

   // TX FIFO: pointers carry one extra wrap bit to tell full from empty.
   assign tx_empty = (wptr == rptr);
   assign tx_full  = (wptr[TXFIFO_LOG2] != rptr[TXFIFO_LOG2]) &&
                     (wptr[TXFIFO_LOG2-1:0] == rptr[TXFIFO_LOG2-1:0]);
   assign tx_idle  = tx_empty && (tx_state == TX_IDLE);
   assign tx_last  = (tx_cnt == tx_div - 16'd1);
   assign fifo_pop = !tx_empty &&
                     ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_last));

   always_ff @(posedge clk) begin
      if (fifo_push)
         fifo_mem[wptr[TXFIFO_LOG2-1:0]] <= iomem_wdata[7:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (fifo_push) wptr <= wptr + 1'b1;
         if (fifo_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= 16'd2;
         tx_bit   <= '0;
         tx_shift <= '0;
         ser_tx   <= 1'b1;
      end else if (fifo_pop) begin
         tx_state <= TX_START;
         tx_shift <= fifo_mem[rptr[TXFIFO_LOG2-1:0]];
         tx_div   <= eff_div;
         tx_cnt   <= '0;
         ser_tx   <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: ser_tx <= 1'b1;
            TX_START: begin
               if (tx_last) begin
                  tx_state <= TX_DATA;
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  ser_tx   <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_last) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_state <= TX_STOP;
                     ser_tx   <= 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     ser_tx   <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_last) tx_state <= TX_IDLE;
               else         tx_cnt   <= tx_cnt + 16'd1;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // RX: sample mid-bit by waiting half a period after the falling start edge.
   assign rx_half       = {1'b0, rx_div[15:1]};
   assign rx_last       = (rx_cnt == rx_div - 16'd1);
   assign rx_start_done = (rx_cnt == rx_half - 16'd1);
   assign rx_deliver    = (rx_state == RX_STOP) && rx_last && rx_s2;
   assign rx_frame_err  = (rx_state == RX_STOP) && rx_last && !rx_s2;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= 16'd2;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_s1   <= ser_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= RX_START;
                  rx_div   <= eff_div;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_start_done) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_last) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_last) begin
                  rx_state <= RX_IDLE;
                  rx_cnt   <= '0;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iomem_uart.sv
// Directed bench for iomem_uart: bus handshake, register map, TX framing,
// FIFO stall, RX delivery/overrun/glitch/framing and mid-frame reset.
module tb_iomem_uart;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = '0;
   logic [31:0] iomem_addr = '0;
   logic [31:0] iomem_wdata = '0;
   logic [31:0] iomem_rdata;
   logic        ser_tx;
   logic        ser_rx = 1'b1;

   localparam logic [31:0] A_DATA = 32'h0200_0000;
   localparam logic [31:0] A_STAT = 32'h0200_0004;
   localparam logic [31:0] A_DIV  = 32'h0200_0008;
   localparam logic [31:0] A_RSVD = 32'h0200_000C;

   int errors = 0;
   int checks = 0;

   iomem_uart dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .ser_tx      (ser_tx),
      .ser_rx      (ser_rx)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bus transaction; lat = cycles from valid to ready, -1 on timeout.
   task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int budget,
                           output logic [31:0] rd, output int lat);
      iomem_addr  = addr;
      iomem_wstrb = wstrb;
      iomem_wdata = wdata;
      iomem_valid = 1'b1;
      lat = -1;
      rd  = '0;
      for (int n = 1; n <= budget; n++) begin
         @(posedge clk); #1;
         if (iomem_ready) begin
            lat = n;
            rd  = iomem_rdata;
            break;
         end
      end
      iomem_valid = 1'b0;
      iomem_wstrb = '0;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output int lat);
      logic [31:0] dummy;
      bus_xfer(addr, wstrb, wdata, 200, dummy, lat);
      if (lat < 0) check("bus_write_timeout", 32'd0, 32'd1);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      int lat;
      bus_xfer(addr, 4'h0, 32'h0, 200, data, lat);
      if (lat < 0) check("bus_read_timeout", 32'd0, 32'd1);
   endtask

   // Waits for the start bit, then checks every cycle of the 10-bit frame.
   task automatic tx_frame(input logic [7:0] b, input int div, output int gap);
      logic [9:0] pat;
      int bad;
      pat = {1'b1, b, 1'b0};
      bad = 0;
      gap = 0;
      while (ser_tx !== 1'b0 && gap < 1000) begin
         @(posedge clk); #1;
         gap++;
      end
      check("tx_start_seen", {31'h0, ser_tx}, 32'h0);
      for (int i = 0; i < 10 * div; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         if (ser_tx !== pat[i / div]) bad++;
      end
      check($sformatf("tx_frame_%h", b), bad, 0);
   endtask

   task automatic rx_send(input logic [7:0] b, input int div, input logic stop_bit);
      logic [9:0] pat;
      pat = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         ser_rx = pat[i];
         repeat (div) @(posedge clk);
         #1;
      end
      ser_rx = 1'b1;
   endtask

   logic [31:0] d;
   int lat;
   int lats [6];
   int gaps [6];
   logic [7:0] burst [6];

   initial begin
      burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hC3;
      burst[3] = 8'h3C; burst[4] = 8'hFF; burst[5] = 8'h00;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      check("reset_ser_tx", {31'h0, ser_tx}, 32'h1);
      check("reset_ready", {31'h0, iomem_ready}, 32'h0);
      check("reset_rdata", iomem_rdata, 32'h0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // STATUS after reset, one-cycle ready latency and pulse width
      bus_xfer(A_STAT, 4'h0, 32'h0, 20, d, lat);
      check("status_reset", d, 32'h2);
      check("ready_latency", lat, 1);
      check("ready_one_cycle", {31'h0, iomem_ready}, 32'h0);
      check("rdata_held", iomem_rdata, 32'h2);

      // DIV register
      rd(A_DIV, d);
      check("div_reset", d, 32'd104);
      wr(A_DIV, 32'hABCD_1234, 4'b0011, lat);
      rd(A_DIV, d);
      check("div_wstrb", d, 32'h0000_1234);
      wr(A_DIV, 32'h0000_0056, 4'b0001, lat);
      rd(A_DIV, d);
      check("div_low_byte", d, 32'h0000_1256);
      wr(A_DIV, 32'h4, 4'b0011, lat);
      rd(A_DIV, d);
      check("div_4", d, 32'h4);
      rd(A_RSVD, d);
      check("reserved_read", d, 32'h0);

      // Single TX frame at DIV=4
      wr(A_DATA, 32'h55, 4'b0001, lat);
      tx_frame(8'h55, 4, lat);
      repeat (3) @(posedge clk);
      #1;
      rd(A_STAT, d);
      check("status_after_tx", d, 32'h2);

      // Six writes back-to-back: the sixth stalls, frames are contiguous
      fork
         begin
            for (int k = 0; k < 6; k++) wr(A_DATA, {24'h0, burst[k]}, 4'b0001, lats[k]);
         end
         begin
            for (int k = 0; k < 6; k++) tx_frame(burst[k], 4, gaps[k]);
         end
      join
      for (int k = 0; k < 5; k++) check($sformatf("burst_lat_%0d", k), lats[k], 1);
      check("burst_write6_stalls", {31'h0, lats[5] > 20}, 32'h1);
      for (int k = 1; k < 6; k++) check($sformatf("burst_gap_%0d", k), gaps[k], 1);
      repeat (3) @(posedge clk);
      #1;
      rd(A_STAT, d);
      check("status_after_burst", d, 32'h2);

      // RX single frame at DIV=8
      wr(A_DIV, 32'h8, 4'b0011, lat);
      rx_send(8'hA3, 8, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      rd(A_STAT, d);
      check("status_rx_valid", d, 32'h6);
      rd(A_DATA, d);
      check("rx_data_a3", d, 32'h0000_00A3);
      rd(A_DATA, d);
      check("rx_empty_read", d, 32'hFFFF_FFFF);

      // Overrun
      rx_send(8'h11, 8, 1'b1);
      rx_send(8'h22, 8, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      rd(A_STAT, d);
      check("status_overrun", d, 32'hE);
      rd(A_DATA, d);
      check("rx_keeps_first", d, 32'h0000_0011);
      rd(A_STAT, d);
      check("status_overrun_sticky", d, 32'hA);
      wr(A_STAT, 32'h8, 4'b0001, lat);
      rd(A_STAT, d);
      check("overrun_cleared", d, 32'h2);

      // 3-cycle glitch is rejected
      ser_rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ser_rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      rd(A_STAT, d);
      check("glitch_rejected", d, 32'h2);

      // Framing error
      rx_send(8'h5A, 8, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rd(A_STAT, d);
      check("status_framing", d, 32'h12);
      rd(A_DATA, d);
      check("framing_discards", d, 32'hFFFF_FFFF);
      wr(A_STAT, 32'h10, 4'b0001, lat);
      rd(A_STAT, d);
      check("framing_cleared", d, 32'h2);

      // Reset mid-frame
      wr(A_DATA, 32'h00, 4'b0001, lat);
      repeat (6) @(posedge clk);
      #1;
      check("tx_busy_before_reset", {31'h0, ser_tx}, 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      check("reset_async_ser_tx", {31'h0, ser_tx}, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      rd(A_STAT, d);
      check("status_after_reset", d, 32'h2);
      rd(A_DIV, d);
      check("div_after_reset", d, 32'd104);
      repeat (20) @(posedge clk);
      #1;
      check("tx_quiet_after_reset", {31'h0, ser_tx}, 32'h1);

      // Outside the window: never answered
      bus_xfer(32'h0300_0000, 4'h0, 32'h0, 30, d, lat);
      check("out_of_window_no_ready", lat, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
